// File: rtl/spectrum_peak.sv
// Sweeps N_BINS DFT amplitudes after each dft_done_in rising edge and reports the peak bin,
// its cos/sin sums and the number of bins above threshold; results land N_BINS+1 cycles after the trigger edge.
module spectrum_peak #(
    parameter int N_BINS  = 128,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        dft_done_in,
    input  logic [31:0] ampl_in,
    input  logic [31:0] cos_in,
    input  logic [31:0] sin_in,
    input  logic [31:0] threshold_in,
    output logic [6:0]  ampl_number_out,
    output logic [6:0]  harm_number_out,
    output logic [6:0]  peak_index,
    output logic [31:0] peak_ampl,
    output logic [31:0] peak_cos,
    output logic [31:0] peak_sin,
    output logic [7:0]  above_count,
    output logic        busy,
    output logic        peak_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_FETCH
    } state_t;

    localparam logic [6:0] LAST_BIN = 7'(N_BINS - 1);

    state_t      r_state;
    logic        r_done_q;
    logic        r_armed;
    logic [6:0]  r_addr;
    logic [6:0]  r_harm;
    logic [6:0]  r_max_idx;
    logic [30:0] r_max_mag;
    logic [31:0] r_max_ampl;
    logic [30:0] r_thr_mag;
    logic        r_thr_neg;
    logic [7:0]  r_cnt;
    logic [6:0]  r_peak_idx;
    logic [31:0] r_peak_ampl;
    logic [31:0] r_peak_cos;
    logic [31:0] r_peak_sin;
    logic [7:0]  r_above;
    logic        r_busy;
    logic        r_valid;

    logic        w_start;
    logic [30:0] w_mag;
    logic        w_nan;
    logic        w_excl;
    logic        w_upd;
    logic        w_above;
    logic        w_last;
    logic [6:0]  w_next_idx;
    logic [7:0]  w_cnt_inc;

    // r_armed blocks a level still high at reset release from looking like a fresh edge
    assign w_start    = r_armed & dft_done_in & ~r_done_q;
    assign w_mag      = ampl_in[30:0];
    assign w_nan      = (ampl_in[30:23] == 8'hFF) && (ampl_in[22:0] != 23'd0);
    assign w_excl     = w_nan || (SKIP_DC && (r_addr == 7'd0));
    assign w_upd      = !w_excl && (w_mag > r_max_mag);
    // a negative threshold is exceeded by every magnitude except 0 against -0.0
    assign w_above    = !w_excl && (r_thr_neg ? ((r_thr_mag != 31'd0) || (w_mag != 31'd0))
                                              : (w_mag > r_thr_mag));
    assign w_last     = (r_addr == LAST_BIN);
    assign w_next_idx = w_upd ? r_addr : r_max_idx;
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (n_reset) begin
            r_state     <= S_IDLE;
            r_done_q    <= 1'b0;
            r_armed     <= 1'b0;
            r_addr      <= 7'd0;
            r_harm      <= 7'd0;
            r_max_idx   <= 7'd0;
            r_max_mag   <= 31'd0;
            r_max_ampl  <= 32'd0;
            r_thr_mag   <= 31'd0;
            r_thr_neg   <= 1'b0;
            r_cnt       <= 8'd0;
            r_peak_idx  <= 7'd0;
            r_peak_ampl <= 32'd0;
            r_peak_cos  <= 32'd0;
            r_peak_sin  <= 32'd0;
            r_above     <= 8'd0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_done_q <= dft_done_in;
            r_armed  <= 1'b1;
            r_valid  <= 1'b0;
            if (w_start) begin
                // also serves as restart when a new spectrum arrives mid-sweep
                r_state    <= S_SWEEP;
                r_busy     <= 1'b1;
                r_addr     <= 7'd0;
                r_max_idx  <= 7'd0;
                r_max_mag  <= 31'd0;
                r_max_ampl <= 32'd0;
                r_cnt      <= 8'd0;
                r_thr_mag  <= threshold_in[30:0];
                r_thr_neg  <= threshold_in[31];
            end else begin
                case (r_state)
                    S_SWEEP: begin
                        if (w_upd) begin
                            r_max_idx  <= r_addr;
                            r_max_mag  <= w_mag;
                            r_max_ampl <= ampl_in;
                        end
                        if (w_above) begin
                            r_cnt <= w_cnt_inc;
                        end
                        if (w_last) begin
                            r_addr  <= 7'd0;
                            r_harm  <= w_next_idx;
                            r_state <= S_FETCH;
                        end else begin
                            r_addr <= r_addr + 7'd1;
                        end
                    end
                    S_FETCH: begin
                        r_peak_idx  <= r_max_idx;
                        r_peak_ampl <= r_max_ampl;
                        r_peak_cos  <= cos_in;
                        r_peak_sin  <= sin_in;
                        r_above     <= r_cnt;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    default: begin
                        r_addr  <= 7'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ampl_number_out = r_addr;
    assign harm_number_out = r_harm;
    assign peak_index      = r_peak_idx;
    assign peak_ampl       = r_peak_ampl;
    assign peak_cos        = r_peak_cos;
    assign peak_sin        = r_peak_sin;
    assign above_count     = r_above;
    assign busy            = r_busy;
    assign peak_valid      = r_valid;

endmodule

// File: tb/tb_spectrum_peak.sv
// Scoreboard bench: two DUTs (SKIP_DC=1 and SKIP_DC=0) share one DFT model;
// expected results are queued at trigger time and checked whenever peak_valid pulses.
module tb_spectrum_peak;

    typedef struct {
        logic [6:0]  idx;
        logic [31:0] ampl;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        done;
    logic [31:0] thr_in;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [31:0] amem [128];
    logic [31:0] cmem [128];
    logic [31:0] smem [128];

    logic [31:0] ampl_1, cos_1, sin_1, pampl_1, pcos_1, psin_1;
    logic [6:0]  anum_1, hnum_1, pidx_1;
    logic [7:0]  cnt_1;
    logic        busy_1, pv_1;
    logic [31:0] ampl_0, cos_0, sin_0, pampl_0, pcos_0, psin_0;
    logic [6:0]  anum_0, hnum_0, pidx_0;
    logic [7:0]  cnt_0;
    logic        busy_0, pv_0;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ampl_1 = amem[anum_1];
    assign cos_1  = cmem[hnum_1];
    assign sin_1  = smem[hnum_1];
    assign ampl_0 = amem[anum_0];
    assign cos_0  = cmem[hnum_0];
    assign sin_0  = smem[hnum_0];

    spectrum_peak #(.N_BINS(128), .SKIP_DC(1'b1)) u_skip (
        .clk(clk), .n_reset(n_reset), .dft_done_in(done),
        .ampl_in(ampl_1), .cos_in(cos_1), .sin_in(sin_1), .threshold_in(thr_in),
        .ampl_number_out(anum_1), .harm_number_out(hnum_1), .peak_index(pidx_1),
        .peak_ampl(pampl_1), .peak_cos(pcos_1), .peak_sin(psin_1),
        .above_count(cnt_1), .busy(busy_1), .peak_valid(pv_1)
    );

    spectrum_peak #(.N_BINS(128), .SKIP_DC(1'b0)) u_dc (
        .clk(clk), .n_reset(n_reset), .dft_done_in(done),
        .ampl_in(ampl_0), .cos_in(cos_0), .sin_in(sin_0), .threshold_in(thr_in),
        .ampl_number_out(anum_0), .harm_number_out(hnum_0), .peak_index(pidx_0),
        .peak_ampl(pampl_0), .peak_cos(pcos_0), .peak_sin(psin_0),
        .above_count(cnt_0), .busy(busy_0), .peak_valid(pv_0)
    );

    function automatic logic [31:0] cos_of(input logic [6:0] k);
        return 32'h3000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] sin_of(input logic [6:0] k);
        return 32'hB100_0000 + 32'(k) * 3;
    endfunction

    function automatic logic [31:0] i2f(input int k);
        int          p;
        logic [31:0] m;
        if (k == 0) return 32'd0;
        p = 0;
        for (int b = 0; b < 31; b++) if ((k >> b) != 0) p = b;
        m = 32'(k) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cmp_res(input string tag, input exp_t e, input logic [6:0] idx,
                           input logic [31:0] a, input logic [31:0] c, input logic [31:0] s,
                           input logic [7:0] n);
        chk({tag, "_peak_index"}, 32'(idx), 32'(e.idx));
        chk({tag, "_peak_ampl"}, a, e.ampl);
        chk({tag, "_peak_cos"}, c, cos_of(e.idx));
        chk({tag, "_peak_sin"}, s, sin_of(e.idx));
        chk({tag, "_above_count"}, 32'(n), 32'(e.cnt));
        chk({tag, "_latency_cycle"}, 32'(cyc), 32'(e.cyc));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pv_1) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL skip_unexpected_pulse actual=1 required=0 cycle=%0d", cyc);
            end else begin
                e = q1.pop_front();
                cmp_res("skip", e, pidx_1, pampl_1, pcos_1, psin_1, cnt_1);
            end
        end
        if (pv_0) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dc_unexpected_pulse actual=1 required=0 cycle=%0d", cyc);
            end else begin
                e = q0.pop_front();
                cmp_res("dc", e, pidx_0, pampl_0, pcos_0, psin_0, cnt_0);
            end
        end
    end

    task automatic push_exp(input logic [6:0] i1, input logic [31:0] a1, input logic [7:0] c1,
                            input logic [6:0] i0, input logic [31:0] a0, input logic [7:0] c0);
        exp_t e;
        // trigger edge is cyc+1; result cycle begins N_BINS+1 edges later
        e.cyc = cyc + 130;
        e.idx = i1; e.ampl = a1; e.cnt = c1; q1.push_back(e);
        e.idx = i0; e.ampl = a0; e.cnt = c0; q0.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q1.size() != 0 || q0.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (q1.size() != 0 || q0.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL result_timeout actual=%0d/%0d pending required=0", q1.size(), q0.size());
            q1.delete();
            q0.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic run_vec(input logic [31:0] thr, input int hold,
                           input logic [6:0] i1, input logic [31:0] a1, input logic [7:0] c1,
                           input logic [6:0] i0, input logic [31:0] a0, input logic [7:0] c0);
        @(negedge clk);
        thr_in = thr;
        done   = 1'b1;
        push_exp(i1, a1, c1, i0, a0, c0);
        repeat ((hold > 1) ? hold : 1) @(negedge clk);
        done = 1'b0;
        wait_idle();
    endtask

    task automatic wait_addr(input logic [6:0] target);
        int k;
        k = 0;
        while (anum_1 != target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (anum_1 != target) begin
            n_chk++; n_fail++;
            $display("FAIL addr_timeout actual=%0d required=%0d", anum_1, target);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int k = 0; k < 128; k++) amem[k] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 128; k++) begin
            cmem[k] = cos_of(7'(k));
            smem[k] = sin_of(7'(k));
            amem[k] = 32'd0;
        end
        n_reset = 1'b1;
        done    = 1'b0;
        thr_in  = 32'd0;
        repeat (3) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        chk("rst_peak_index", 32'(pidx_1), 32'd0);
        chk("rst_peak_ampl", pampl_1, 32'd0);
        chk("rst_peak_cos", pcos_1, 32'd0);
        chk("rst_peak_sin", psin_1, 32'd0);
        chk("rst_above_count", 32'(cnt_1), 32'd0);
        chk("rst_busy", 32'(busy_1), 32'd0);
        chk("rst_peak_valid", 32'(pv_1), 32'd0);
        chk("rst_ampl_number", 32'(anum_1), 32'd0);
        chk("rst_harm_number", 32'(hnum_1), 32'd0);

        // ramp: bin k = k.0, threshold 100.0
        for (int k = 0; k < 128; k++) amem[k] = i2f(k);
        run_vec(32'h42C8_0000, 1, 7'd127, 32'h42FE_0000, 8'd27, 7'd127, 32'h42FE_0000, 8'd27);

        // tie between bins 5 and 9; dft_done_in held high must not retrigger
        fill(32'h3F80_0000);
        amem[5] = 32'h4040_0000;
        amem[9] = 32'h4040_0000;
        run_vec(32'h4000_0000, 300, 7'd5, 32'h4040_0000, 8'd2, 7'd5, 32'h4040_0000, 8'd2);

        // DC bin dominant
        fill(32'h3F80_0000);
        amem[0] = 32'h447A_0000;
        run_vec(32'h4000_0000, 1, 7'd1, 32'h3F80_0000, 8'd0, 7'd0, 32'h447A_0000, 8'd1);

        // NaN excluded, negative amplitude ranked by magnitude
        fill(32'd0);
        amem[40] = 32'h7FC0_0000;
        amem[41] = 32'hC120_0000;
        run_vec(32'h40A0_0000, 1, 7'd41, 32'hC120_0000, 8'd1, 7'd41, 32'hC120_0000, 8'd1);

        // every bin NaN: no qualifying peak
        fill(32'h7FC0_0000);
        run_vec(32'h3F80_0000, 1, 7'd0, 32'd0, 8'd0, 7'd0, 32'd0, 8'd0);

        // infinity beats the largest finite value
        fill(32'd0);
        amem[20] = 32'h7F7F_FFFF;
        amem[77] = 32'h7F80_0000;
        run_vec(32'd0, 1, 7'd77, 32'h7F80_0000, 8'd2, 7'd77, 32'h7F80_0000, 8'd2);

        // restart at bin 60: only the second trigger produces a result
        for (int k = 0; k < 128; k++) amem[k] = i2f(k);
        @(negedge clk);
        thr_in = 32'h42C8_0000;
        done   = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_addr(7'd60);
        done = 1'b1;
        push_exp(7'd127, 32'h42FE_0000, 8'd27, 7'd127, 32'h42FE_0000, 8'd27);
        @(negedge clk);
        done = 1'b0;
        wait_idle();

        // reset at bin 30 aborts silently and clears results
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_addr(7'd30);
        n_reset = 1'b1;
        @(negedge clk);
        n_reset = 1'b0;
        chk("abort_peak_index", 32'(pidx_1), 32'd0);
        chk("abort_peak_ampl", pampl_1, 32'd0);
        chk("abort_above_count", 32'(cnt_1), 32'd0);
        chk("abort_busy", 32'(busy_1), 32'd0);
        chk("abort_ampl_number", 32'(anum_1), 32'd0);
        chk("abort_harm_number", 32'(hnum_1), 32'd0);
        chk("abort_dc_peak_ampl", pampl_0, 32'd0);

        // dft_done_in high across reset release must not start a sweep
        @(negedge clk);
        done    = 1'b1;
        n_reset = 1'b1;
        @(negedge clk);
        n_reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_release_busy_skip", 32'(busy_1), 32'd0);
        chk("held_release_busy_dc", 32'(busy_0), 32'd0);
        chk("held_release_addr", 32'(anum_1), 32'd0);
        done = 1'b0;
        repeat (3) @(negedge clk);

        fill(32'd0);
        amem[40] = 32'h7FC0_0000;
        amem[41] = 32'hC120_0000;
        run_vec(32'h40A0_0000, 1, 7'd41, 32'hC120_0000, 8'd1, 7'd41, 32'hC120_0000, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
